// File: rtl/csa_acc_pipe_if.sv
// Handshake bundle for the carry-save accumulator: operand beats in, resolved
// group sums out. The producer/consumer side uses master, the accumulator uses slave.
interface csa_acc_pipe_if #(
    parameter int DW = 16,
    parameter int N  = 6,
    parameter int OW = 32,
    parameter int CW = 8
);
    logic            in_valid;
    logic            in_ready;
    logic            in_last;
    logic [N*DW-1:0] in_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_data;
    logic [CW-1:0]   out_beats;

    modport master (
        output in_valid, in_last, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_beats
    );

    modport slave (
        input  in_valid, in_last, in_data, out_ready,
        output in_ready, out_valid, out_data, out_beats
    );
endinterface

// File: rtl/csa_acc_pipe.sv
// Pipelined multi-operand carry-save accumulator: N operands per beat are folded
// into a redundant sum/carry pair; one carry-propagate add resolves each group.
module csa_acc_pipe #(
    parameter int DW     = 16,
    parameter int N      = 6,
    parameter int OW     = 32,
    parameter bit SIGNED = 1'b0,
    parameter int CW     = 8
) (
    input logic            clk,
    input logic            reset,
    csa_acc_pipe_if.slave  bus
);

    localparam int NT = N + 2;

    // A 3:2 level turns every full triple into two terms and passes leftovers through.
    function automatic int next_terms(input int m);
        return 2 * (m / 3) + (m % 3);
    endfunction

    function automatic int terms_at(input int lvl_idx);
        int m;
        m = NT;
        for (int k = 0; k < lvl_idx; k++) m = next_terms(m);
        return m;
    endfunction

    function automatic int num_levels(input int m);
        int l;
        int t;
        l = 0;
        t = m;
        while (t > 2) begin
            t = next_terms(t);
            l++;
        end
        return l;
    endfunction

    localparam int NL = num_levels(NT);

    logic [OW-1:0] acc_s;
    logic [OW-1:0] acc_c;
    logic [CW-1:0] cnt;
    logic          pend;
    logic          fresh;
    logic          out_valid_q;
    logic [OW-1:0] out_data_q;
    logic [CW-1:0] out_beats_q;

    logic          in_ready;
    logic          accept;
    logic          transfer;

    logic [OW-1:0] lvl [NL+1][NT];

    assign transfer = pend & (~out_valid_q | bus.out_ready);
    assign in_ready = ~pend | transfer;
    assign accept   = bus.in_valid & in_ready;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_beats = out_beats_q;

    for (genvar k = 0; k < N; k++) begin : g_ext
        logic [DW-1:0] op;
        assign op = bus.in_data[k*DW +: DW];
        if (SIGNED) begin : g_sext
            assign lvl[0][k] = {{(OW-DW){op[DW-1]}}, op};
        end else begin : g_zext
            assign lvl[0][k] = {{(OW-DW){1'b0}}, op};
        end
    end

    // The first beat of a group must not see the previous group's residue.
    assign lvl[0][N]   = fresh ? '0 : acc_s;
    assign lvl[0][N+1] = fresh ? '0 : acc_c;

    for (genvar l = 0; l < NL; l++) begin : g_lvl
        localparam int M  = terms_at(l);
        localparam int G  = M / 3;
        localparam int MN = next_terms(M);
        for (genvar i = 0; i < NT; i++) begin : g_term
            if (i < 2 * G) begin : g_csa
                logic [OW-1:0] a;
                logic [OW-1:0] b;
                logic [OW-1:0] c;
                assign a = lvl[l][3*(i/2)];
                assign b = lvl[l][3*(i/2)+1];
                assign c = lvl[l][3*(i/2)+2];
                if (i % 2 == 0) begin : g_sum
                    assign lvl[l+1][i] = a ^ b ^ c;
                end else begin : g_carry
                    // Carry weight moves up one bit; the MSB carry falls off (mod 2^OW).
                    assign lvl[l+1][i] = ((a & b) | (a & c) | (b & c)) << 1;
                end
            end else if (i < MN) begin : g_pass
                assign lvl[l+1][i] = lvl[l][3*G + i - 2*G];
            end else begin : g_zero
                assign lvl[l+1][i] = '0;
            end
        end
    end

    // NOTE: all registered state uses non-blocking assignments so every register
    // samples pre-edge values; transfer relies on this to read acc_s/acc_c before
    // a same-edge accept overwrites them.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_s       <= '0;
            acc_c       <= '0;
            cnt         <= '0;
            pend        <= 1'b0;
            fresh       <= 1'b1;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_beats_q <= '0;
        end else begin
            if (accept) begin
                acc_s <= lvl[NL][0];
                acc_c <= lvl[NL][1];
                if (fresh)
                    cnt <= CW'(1);
                else if (cnt != '1)
                    cnt <= cnt + CW'(1);
                fresh <= bus.in_last;
            end

            if (transfer) begin
                out_data_q  <= acc_s + acc_c;
                out_beats_q <= cnt;
                out_valid_q <= 1'b1;
            end else if (out_valid_q && bus.out_ready) begin
                out_valid_q <= 1'b0;
            end

            // A closing beat accepted alongside a transfer keeps the next group pending.
            if (accept && bus.in_last)
                pend <= 1'b1;
            else if (transfer)
                pend <= 1'b0;
        end
    end

endmodule

// File: tb/tb_csa_acc_pipe.sv
// Bench for csa_acc_pipe: three instances (unsigned/32, signed/32, unsigned/19 with
// a 2-bit beat counter) share one stimulus stream and are scored against a group-sum model.
module tb_csa_acc_pipe;

    localparam int DW = 16;
    localparam int N  = 6;
    localparam int OWK [3] = '{32, 32, 19};
    localparam int CWK [3] = '{8, 8, 2};
    localparam bit SGNK [3] = '{1'b0, 1'b1, 1'b0};

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_last;
    logic [N*DW-1:0] in_data;
    logic            out_ready;

    always #5 clk = ~clk;

    csa_acc_pipe_if #(.DW(DW), .N(N), .OW(32), .CW(8)) b0 ();
    csa_acc_pipe_if #(.DW(DW), .N(N), .OW(32), .CW(8)) b1 ();
    csa_acc_pipe_if #(.DW(DW), .N(N), .OW(19), .CW(2)) b2 ();

    assign b0.in_valid = in_valid;  assign b0.in_last = in_last;
    assign b0.in_data  = in_data;   assign b0.out_ready = out_ready;
    assign b1.in_valid = in_valid;  assign b1.in_last = in_last;
    assign b1.in_data  = in_data;   assign b1.out_ready = out_ready;
    assign b2.in_valid = in_valid;  assign b2.in_last = in_last;
    assign b2.in_data  = in_data;   assign b2.out_ready = out_ready;

    csa_acc_pipe #(.DW(DW), .N(N), .OW(32), .SIGNED(1'b0), .CW(8)) u_dut0 (.clk(clk), .reset(reset), .bus(b0));
    csa_acc_pipe #(.DW(DW), .N(N), .OW(32), .SIGNED(1'b1), .CW(8)) u_dut1 (.clk(clk), .reset(reset), .bus(b1));
    csa_acc_pipe #(.DW(DW), .N(N), .OW(19), .SIGNED(1'b0), .CW(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2));

    typedef struct {
        logic [63:0] d;
        int          b;
    } res_t;

    res_t        q [3][$];
    logic [63:0] m_sum [3];
    int          m_beats [3];
    bit          m_fresh [3];

    logic        ov [3];
    logic        ir [3];
    logic [63:0] od [3];
    logic [63:0] ob [3];
    bit          stall_p [3];
    logic [63:0] stall_d [3];
    logic [63:0] stall_b [3];
    logic [63:0] pop_d [3];
    logic [63:0] pop_b [3];
    int          pop_cyc [$];
    bit          acc0;
    int          cyc;
    int          n_tests;
    int          n_fail;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ext(input int k, input logic [DW-1:0] v);
        logic [63:0] x;
        x = {48'd0, v};
        if (SGNK[k] && v[DW-1]) x[63:DW] = '1;
        return x;
    endfunction

    // Group-level reference: add every extended operand of the group, wrap to OW,
    // saturate the beat count to the counter width.
    task automatic model_accept(input int k);
        res_t r;
        int   mx;
        if (m_fresh[k]) begin
            m_sum[k]   = '0;
            m_beats[k] = 0;
        end
        for (int j = 0; j < N; j++) m_sum[k] = m_sum[k] + ext(k, in_data[j*DW +: DW]);
        m_beats[k]++;
        m_fresh[k] = in_last;
        if (in_last) begin
            mx  = (1 << CWK[k]) - 1;
            r.d = m_sum[k] & ((64'd1 << OWK[k]) - 64'd1);
            r.b = (m_beats[k] > mx) ? mx : m_beats[k];
            q[k].push_back(r);
        end
    endtask

    task automatic sample();
        ov[0] = b0.out_valid; ir[0] = b0.in_ready; od[0] = 64'(b0.out_data); ob[0] = 64'(b0.out_beats);
        ov[1] = b1.out_valid; ir[1] = b1.in_ready; od[1] = 64'(b1.out_data); ob[1] = 64'(b1.out_beats);
        ov[2] = b2.out_valid; ir[2] = b2.in_ready; od[2] = 64'(b2.out_data); ob[2] = 64'(b2.out_beats);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            q[k].delete();
            m_fresh[k] = 1'b1;
            m_sum[k]   = '0;
            m_beats[k] = 0;
            stall_p[k] = 1'b0;
        end
    endtask

    // One clock: score what happens at the coming edge, then step past it.
    task automatic cycle();
        res_t e;
        #1;
        sample();
        for (int k = 0; k < 3; k++) begin
            if (stall_p[k]) begin
                check($sformatf("hold_valid%0d", k), 64'(ov[k]), 64'd1);
                check($sformatf("hold_data%0d", k), od[k], stall_d[k]);
                check($sformatf("hold_beats%0d", k), ob[k], stall_b[k]);
            end
            if (ov[k] && out_ready) begin
                if (q[k].size() == 0) begin
                    check($sformatf("spurious_valid%0d", k), 64'(ov[k]), 64'd0);
                end else begin
                    e = q[k].pop_front();
                    check($sformatf("data%0d", k), od[k], e.d);
                    check($sformatf("beats%0d", k), ob[k], 64'(e.b));
                    pop_d[k] = od[k];
                    pop_b[k] = ob[k];
                    if (k == 0) pop_cyc.push_back(cyc);
                end
            end
            stall_p[k] = ov[k] && !out_ready;
            stall_d[k] = od[k];
            stall_b[k] = ob[k];
            if (in_valid && ir[k]) model_accept(k);
        end
        acc0 = in_valid && ir[0];
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send(input logic [N*DW-1:0] d, input bit last, input bit rnd_rdy);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        acc0     = 1'b0;
        for (int t = 0; t < 200; t++) begin
            if (rnd_rdy) out_ready = 1'($urandom_range(0, 1));
            cycle();
            if (acc0) break;
        end
        if (!acc0) check("accept_timeout", 64'(acc0), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        for (int t = 0; t < 100; t++) begin
            if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
            cycle();
        end
        check("drain_left", 64'(q[0].size() + q[1].size() + q[2].size()), 64'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        #2;
        sample();
        for (int k = 0; k < 3; k++) begin
            check($sformatf("rst_valid%0d", k), 64'(ov[k]), 64'd0);
            check($sformatf("rst_ready%0d", k), 64'(ir[k]), 64'd1);
            check($sformatf("rst_data%0d", k), od[k], 64'd0);
            check($sformatf("rst_beats%0d", k), ob[k], 64'd0);
        end
        @(posedge clk);
        #3;
        reset = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [N*DW-1:0] fill(input logic [DW-1:0] v);
        logic [N*DW-1:0] d;
        for (int j = 0; j < N; j++) d[j*DW +: DW] = v;
        return d;
    endfunction

    function automatic logic [N*DW-1:0] rnd_data();
        logic [N*DW-1:0] d;
        for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'($urandom);
        return d;
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [N*DW-1:0] d;
        int              c0;
        int              glen;
        logic [63:0]     exp_b;

        n_tests   = 0;
        n_fail    = 0;
        cyc       = 0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        reset     = 1'b0;
        #1;
        do_reset();

        // Single beat 1..6: result shows two cycles after the accepting cycle.
        out_ready = 1'b1;
        for (int j = 0; j < N; j++) d[j*DW +: DW] = DW'(j + 1);
        send(d, 1'b1, 1'b0);
        check("lat_not_early", 64'(b0.out_valid), 64'd0);
        cycle();
        check("lat_valid", 64'(b0.out_valid), 64'd1);
        check("lat_data", 64'(b0.out_data), 64'd21);
        check("lat_beats", 64'(b0.out_beats), 64'd1);
        drain();

        // Three all-ones beats: unsigned, signed and 19-bit wrap.
        send(fill(16'hFFFF), 1'b0, 1'b0);
        send(fill(16'hFFFF), 1'b0, 1'b0);
        send(fill(16'hFFFF), 1'b1, 1'b0);
        drain();
        check("ones_unsigned", pop_d[0], 64'd1179630);
        check("ones_signed", pop_d[1], 64'hFFFF_FFEE);
        check("ones_wrap19", pop_d[2], 64'd131054);
        check("ones_beats", pop_b[0], 64'd3);

        // Five-beat group: 2-bit counter saturates at 3.
        for (int i = 0; i < 5; i++) send(rnd_data(), (i == 4), 1'b0);
        drain();
        check("sat_beats_cw2", pop_b[2], 64'd3);
        check("beats_cw8", pop_b[0], 64'd5);

        // Stall: result held, second group completes, input then blocks.
        out_ready = 1'b0;
        send(rnd_data(), 1'b1, 1'b0);
        cycle();
        cycle();
        check("stall_presented", 64'(b0.out_valid), 64'd1);
        send(rnd_data(), 1'b0, 1'b0);
        send(rnd_data(), 1'b1, 1'b0);
        in_valid = 1'b1;
        in_data  = rnd_data();
        in_last  = 1'b1;
        cycle();
        check("stall_ready_low_a", 64'(ir[0]), 64'd0);
        cycle();
        check("stall_ready_low_b", 64'(ir[0]), 64'd0);
        out_ready = 1'b1;
        cycle();
        check("release_accept", 64'(acc0), 64'd1);
        in_valid = 1'b0;
        in_last  = 1'b0;
        check("release_next_valid", 64'(b0.out_valid), 64'd1);
        exp_b = (q[0].size() > 0) ? q[0][0].d : 64'hDEAD;
        check("release_next_data", 64'(b0.out_data), exp_b);
        drain();

        // Eight back-to-back single-beat groups at full rate.
        pop_cyc.delete();
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(rnd_data(), 1'b1, 1'b0);
        check("tput_cycles", 64'(cyc - c0), 64'd8);
        drain();
        check("tput_results", 64'(pop_cyc.size()), 64'd8);
        for (int i = 1; i < pop_cyc.size(); i++)
            check($sformatf("tput_consec%0d", i), 64'(pop_cyc[i] - pop_cyc[0]), 64'(i));

        // Random groups under random back-pressure.
        for (int g = 0; g < 20; g++) begin
            glen = int'($urandom_range(1, 5));
            for (int i = 0; i < glen; i++) send(rnd_data(), (i == glen - 1), 1'b1);
        end
        drain();

        // Reset with a presented result: it must vanish.
        out_ready = 1'b0;
        send(rnd_data(), 1'b1, 1'b0);
        cycle();
        cycle();
        do_reset();
        out_ready = 1'b1;
        cycle();
        cycle();

        // Reset after 2 of 4 beats, then one beat of all 2s.
        send(rnd_data(), 1'b0, 1'b0);
        send(rnd_data(), 1'b0, 1'b0);
        do_reset();
        out_ready = 1'b1;
        send(fill(16'd2), 1'b1, 1'b0);
        drain();
        check("abort_data0", pop_d[0], 64'd12);
        check("abort_data1", pop_d[1], 64'd12);
        check("abort_data2", pop_d[2], 64'd12);
        check("abort_beats", pop_b[0], 64'd1);
        cycle();
        check("idle_valid", 64'(b0.out_valid), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
